// File: rtl/spike_rate_decoder_if.sv
// Signal bundle for spike_rate_decoder: network spike input, window control and rate/display outputs.
// The master side (stimulus or top level) drives the inputs; the slave side is the decoder.
interface spike_rate_decoder_if #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 8
);
   logic             ena;
   logic             spike_in;
   logic [LEN_W-1:0] window_len;
   logic [CNT_W-1:0] rate_count;
   logic             rate_valid;
   logic             rate_ovf;
   logic [6:0]       segments;

   modport master (
      output ena, spike_in, window_len,
      input  rate_count, rate_valid, rate_ovf, segments
   );

   modport slave (
      input  ena, spike_in, window_len,
      output rate_count, rate_valid, rate_ovf, segments
   );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts rising spike edges over a window of PRESCALE-cycle ticks and latches the rate for display.
// Define SPIKE_DEC_HEX_EN to show hex 0-F on the segments; otherwise the display clamps to decimal 0-9.
//
// state   | meaning
// ST_LOAD | window start: latch window_len on the next enabled cycle
// ST_RUN  | window in progress with latched length
module spike_rate_decoder #(
   parameter int PRESCALE = 256,
   parameter int LEN_W    = 8,
   parameter int CNT_W    = 8
) (
   input logic                clk,
   input logic                rst_n,
   spike_rate_decoder_if.slave bus
);
   localparam int TICK_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
`ifdef SPIKE_DEC_HEX_EN
   localparam int DISP_MAX = 15;
`else
   localparam int DISP_MAX = 9;
`endif

   typedef enum logic {ST_LOAD, ST_RUN} state_t;

   state_t            state, state_nx;
   logic [TICK_W-1:0] tick_cnt;
   logic [LEN_W-1:0]  win_cnt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_sel;
   logic [LEN_W-1:0]  len_eff;
   logic [CNT_W-1:0]  spike_cnt, spike_cnt_nx;
   logic              ovf, ovf_nx;
   logic              spike_prev;
   logic              edge_hit;
   logic              tick;
   logic              win_end;
   logic              load_len;
   logic [CNT_W-1:0]  rate_count_q;
   logic              rate_valid_q;
   logic              rate_ovf_q;
   logic [31:0]       rate_ext;
   logic [3:0]        digit;
   logic [6:0]        seg;

   // In ST_LOAD the live window_len governs the current cycle so a 1-tick window can end immediately.
   always_comb begin
      edge_hit = bus.spike_in & ~spike_prev & bus.ena;
      tick     = bus.ena && (tick_cnt == TICK_LAST);
      len_sel  = (state == ST_LOAD) ? bus.window_len : len_q;
      len_eff  = (len_sel == '0) ? LEN_W'(1) : len_sel;
      win_end  = tick && (win_cnt == (len_eff - LEN_W'(1)));
      spike_cnt_nx = spike_cnt;
      ovf_nx       = ovf;
      if (edge_hit) begin
         if (spike_cnt == CNT_MAX) ovf_nx = 1'b1;
         else                      spike_cnt_nx = spike_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      load_len = 1'b0;
      case (state)
         ST_LOAD: begin
            if (bus.ena) begin
               load_len = 1'b1;
               state_nx = win_end ? ST_LOAD : ST_RUN;
            end
         end
         ST_RUN: begin
            if (win_end) state_nx = ST_LOAD;
         end
         default: state_nx = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_LOAD;
         spike_prev   <= 1'b0;
         tick_cnt     <= '0;
         win_cnt      <= '0;
         len_q        <= '0;
         spike_cnt    <= '0;
         ovf          <= 1'b0;
         rate_count_q <= '0;
         rate_valid_q <= 1'b0;
         rate_ovf_q   <= 1'b0;
      end else begin
         spike_prev   <= bus.spike_in;
         state        <= state_nx;
         rate_valid_q <= win_end;
         if (load_len) len_q <= len_eff;
         if (bus.ena) tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
         if (win_end) begin
            win_cnt      <= '0;
            spike_cnt    <= '0;
            ovf          <= 1'b0;
            rate_count_q <= spike_cnt_nx;
            rate_ovf_q   <= ovf_nx;
         end else begin
            if (tick) win_cnt <= win_cnt + LEN_W'(1);
            spike_cnt <= spike_cnt_nx;
            ovf       <= ovf_nx;
         end
      end
   end

   always_comb begin
      rate_ext = 32'(rate_count_q);
      digit    = (rate_ext > DISP_MAX) ? 4'(DISP_MAX) : 4'(rate_ext);
      case (digit)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
   end

   assign bus.rate_count = rate_count_q;
   assign bus.rate_valid = rate_valid_q;
   assign bus.rate_ovf   = rate_ovf_q;
   assign bus.segments   = seg;
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder for the spiking oscillator network. It counts rising edges of the network's spike output over a programmable window of prescaled ticks. At the end of each window it latches the count and pulses a valid strobe. It drives the result onto the 7-segment display lines of the top level, so the board shows the firing rate of the network.

## Interface
- `PRESCALE`, default 256: clock cycles per tick, ≥1.
- `LEN_W`, default 8: width of `window_len`.
- `CNT_W`, default 8: width of the spike counter and of `rate_count`.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  design enable; low freezes the tick, window and spike counters.
- `spike_in`  in  1  spike train from the network, synchronous to `clk`.
- `window_len`  in  LEN_W  window length in ticks; 0 is treated as 1.
- `rate_count`  out  CNT_W  spike count of the last completed window, saturated.
- `rate_valid`  out  1  one-cycle strobe when `rate_count` updates.
- `rate_ovf`  out  1  last completed window saturated the counter.
- `segments`  out  7  7-segment code of `rate_count`; bit 0 = a … bit 6 = g, active high.

## Operation
- Edge detect: `spike_prev` is registered every cycle regardless of `ena`.
  - A spike is counted when `spike_in & ~spike_prev & ena`.
  - A held-high input counts once.
- Tick counter runs 0..PRESCALE-1 while `ena`=1; the tick fires on the cycle it equals PRESCALE-1.
- Window counter counts ticks.
  - `window_len` is latched at window start: the first enabled cycle after reset, and the cycle after each window end.
  - Changes mid-window take effect in the next window.
- Window end is the tick cycle on which the window counter reaches the latched length (min 1). Window span is exactly PRESCALE×max(window_len,1) enabled cycles.
- Spike counter saturates at 2^CNT_W−1 and sets an internal overflow flag for the window.
- At window end:
  - `rate_count` ← the counter value including any edge on that same cycle (saturated).
  - `rate_ovf` ← the window's overflow flag, including a saturation caused by that same-cycle edge.
  - Spike counter, overflow flag and window counter clear.
  - An edge on the window-end cycle belongs to the ending window, never to the next one.
- `segments` is decoded combinationally from `rate_count` after clamping (see Configuration). Codes:
  - Digits: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Letters: A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- `ena`=0:
  - All counters and the latched length hold.
  - No tick, no window end, no `rate_valid`.
  - Outputs hold.

## Timing
- Reset values:
  - `rate_count`=0, `rate_valid`=0, `rate_ovf`=0, hence `segments`=0x3F.
  - All counters are 0 and `spike_prev`=0.
- Reset asserted mid-window discards the partial count immediately. The window restarts on the first enabled cycle after release.
- Latency:
  - `rate_count`, `rate_ovf` and `rate_valid` are registered and change on the clock edge ending the window-end cycle.
  - `rate_valid` is high for exactly that following cycle.
  - `segments` follows `rate_count` in the same cycle.
- Spike to counter: an edge at cycle n is visible in the internal count at n+1.
- There is no handshake. Consumers must sample `rate_count` when `rate_valid`=1; it then holds until the next window end.
- Back-to-back windows have no dead cycle. With PRESCALE=1 and `window_len`=1, `rate_valid` is high every cycle.

## Configuration
- `SPIKE_DEC_HEX_EN`:
  - Defined: the display clamps to 15 and shows hex 0–F.
  - Undefined: the display clamps to 9 and shows decimal 0–9.
- `rate_count`, `rate_ovf` and all other behaviour are identical either way.

## Test plan
All scenarios use PRESCALE=4, LEN_W=8, CNT_W=4 unless noted.
- Rate: `window_len`=3, ena=1, five 1-cycle spikes within a 12-cycle window → `rate_valid` pulses once at cycle 12 after reset release, `rate_count`=5, `segments`=0x6D, `rate_ovf`=0.
- Held/edge: `spike_in` high for 8 cycles, then low 1 cycle, then high 1 cycle, within one window → `rate_count`=2. An edge on the window-end cycle is counted in the ending window; the next window reads 0.
- Saturation: 20 spikes in a window with `window_len`=20 → `rate_count`=15, `rate_ovf`=1. Next window with 3 spikes → `rate_count`=3, `rate_ovf`=0.
- Display clamp: 12 spikes → with `SPIKE_DEC_HEX_EN` `segments`=0x39, without it `segments`=0x6F.
- Enable/length:
  - `ena` low for 10 cycles mid-window → window end delayed by exactly 10 cycles, spikes during the gap not counted.
  - `window_len` changed 3→1 mid-window → current window stays 12 cycles, next is 4.
- Reset: assert `rst_n`=0 mid-window after 4 spikes → all outputs return to reset values asynchronously. After release, the first window counts only new spikes.
